// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with start/busy/done handshake and iterative MULTU/DIVU into HI/LO.
// Build option ALU_SIGNED_MULDIV_EN adds signed MULT (1001) and DIV (1011); without it those codes yield 0.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops and divide-by-zero finish here
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// FIN   | final iteration, sign fix-up, write HI/LO/aluOut
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       aluCtrl,
    output logic [WIDTH-1:0] aluOut,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MFHI  = 4'b0011;
    localparam logic [3:0] OP_MFLO  = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1010;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] wrk_q, wrk_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] aluout_q, aluout_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;

    logic             op_mul, op_div;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] simple_res;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic [WIDTH-1:0] step_acc, step_wrk;
    logic [WIDTH-1:0] fin_hi, fin_lo;

`ifdef ALU_SIGNED_MULDIV_EN
    localparam logic [3:0] OP_MULT = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1011;

    logic               op_signed;
    logic               neg_lo_q, neg_hi_q;
    logic [2*WIDTH-1:0] prod_neg;

    assign op_mul    = (aluCtrl == OP_MULTU) || (aluCtrl == OP_MULT);
    assign op_div    = (aluCtrl == OP_DIVU) || (aluCtrl == OP_DIV);
    assign op_signed = aluCtrl[0];
    assign mag_a     = (op_signed && A[WIDTH-1]) ? -A : A;
    assign mag_b     = (op_signed && B[WIDTH-1]) ? -B : B;

    // neg_lo: product / quotient negative; neg_hi: remainder follows dividend sign
    always_ff @(posedge clock) begin
        if (reset) begin
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            neg_lo_q <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_hi_q <= op_signed & A[WIDTH-1];
        end
    end

    always_comb begin
        fin_hi   = step_acc;
        fin_lo   = step_wrk;
        prod_neg = -{step_acc, step_wrk};
        if (is_div_q) begin
            if (neg_lo_q) fin_lo = -step_wrk;
            if (neg_hi_q) fin_hi = -step_acc;
        end else if (neg_lo_q) begin
            fin_hi = prod_neg[2*WIDTH-1:WIDTH];
            fin_lo = prod_neg[WIDTH-1:0];
        end
    end
`else
    assign op_mul = (aluCtrl == OP_MULTU);
    assign op_div = (aluCtrl == OP_DIVU);
    assign mag_a  = A;
    assign mag_b  = B;
    assign fin_hi = step_acc;
    assign fin_lo = step_wrk;
`endif

    always_comb begin
        case (aluCtrl)
            OP_AND:  simple_res = A & B;
            OP_OR:   simple_res = A | B;
            OP_ADD:  simple_res = A + B;
            OP_SUB:  simple_res = A - B;
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_NOR:  simple_res = ~(A | B);
            OP_MFHI: simple_res = hi_q;
            OP_MFLO: simple_res = lo_q;
            default: simple_res = '0;
        endcase
    end

    // acc holds the running high half (mul) or partial remainder (div); wrk holds multiplier/quotient bits
    always_comb begin
        mul_sum   = {1'b0, acc_q} + {1'b0, opb_q};
        div_trial = {acc_q, wrk_q[WIDTH-1]} - {1'b0, opb_q};
        if (is_div_q) begin
            if (!div_trial[WIDTH]) begin
                step_acc = div_trial[WIDTH-1:0];
                step_wrk = {wrk_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = {acc_q[WIDTH-2:0], wrk_q[WIDTH-1]};
                step_wrk = {wrk_q[WIDTH-2:0], 1'b0};
            end
        end else if (wrk_q[0]) begin
            step_acc = mul_sum[WIDTH:1];
            step_wrk = {mul_sum[0], wrk_q[WIDTH-1:1]};
        end else begin
            step_acc = {1'b0, acc_q[WIDTH-1:1]};
            step_wrk = {acc_q[0], wrk_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op_mul)                   state_d = S_MUL;
                    else if (op_div && B != '0)   state_d = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == CNT_ONE) state_d = S_FIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The FIN cycle performs the last of the WIDTH iterations, so busy lasts exactly WIDTH cycles
    always_comb begin
        acc_d     = acc_q;
        wrk_d     = wrk_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        aluout_d  = aluout_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    divzero_d = 1'b0;
                    acc_d     = '0;
                    wrk_d     = mag_a;
                    opb_d     = mag_b;
                    cnt_d     = CNT_LOAD;
                    is_div_d  = op_div;
                    if (op_div && B == '0) begin
                        lo_d      = '1;
                        hi_d      = A;
                        aluout_d  = '1;
                        divzero_d = 1'b1;
                        done_d    = 1'b1;
                    end else if (!op_mul && !op_div) begin
                        aluout_d = simple_res;
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL, S_DIV: begin
                acc_d = step_acc;
                wrk_d = step_wrk;
                cnt_d = cnt_q - CNT_ONE;
            end
            default: begin
                hi_d     = fin_hi;
                lo_d     = fin_lo;
                aluout_d = fin_lo;
                done_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q     <= '0;
            wrk_q     <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            aluout_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            wrk_q     <= wrk_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            aluout_q  <= aluout_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign aluOut  = aluout_q;
    assign zero    = (aluout_q == '0);
    assign done    = done_q;
    assign divZero = divzero_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8; expected results are queued at issue
// and popped by per-instance monitors on done. Signed-op expectations follow ALU_SIGNED_MULDIV_EN.
module tb_alu_seq;
    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD_ = 4'b0010, MFHI = 4'b0011;
    localparam logic [3:0] MFLO = 4'b0100, SUB_ = 4'b0110, SLT_ = 4'b0111, NOR_ = 4'b1100;
    localparam logic [3:0] MULTU = 4'b1000, MULT = 4'b1001, DIVU = 4'b1010, DIV = 4'b1011;

    typedef struct {
        string       nm;
        logic [31:0] out;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        start32, zero32, busy32, done32, dz32;
    logic [31:0] a32, b32, out32, hi32, lo32;
    logic [3:0]  ctrl32;
    logic        start8, zero8, busy8, done8, dz8;
    logic [7:0]  a8, b8, out8, hi8, lo8;
    logic [3:0]  ctrl8;

    exp_t q32[$];
    exp_t q8[$];

    alu_seq #(.WIDTH(32)) u_dut32 (
        .clock(clk), .reset(rst), .start(start32), .A(a32), .B(b32), .aluCtrl(ctrl32),
        .aluOut(out32), .zero(zero32), .busy(busy32), .done(done32), .divZero(dz32),
        .hi(hi32), .lo(lo32)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clock(clk), .reset(rst), .start(start8), .A(a8), .B(b8), .aluCtrl(ctrl8),
        .aluOut(out8), .zero(zero8), .busy(busy8), .done(done8), .divZero(dz8),
        .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done32) begin
            if (q32.size() == 0) begin
                chk("unexpected_done32", 1'b1, 1'b0);
            end else begin
                e = q32.pop_front();
                chk({e.nm, "_out"}, out32, e.out);
                chk({e.nm, "_zero"}, zero32, (e.out == 32'h0));
                chk({e.nm, "_hi"}, hi32, e.hi);
                chk({e.nm, "_lo"}, lo32, e.lo);
                chk({e.nm, "_divzero"}, dz32, e.dz);
                chk({e.nm, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", 1'b1, 1'b0);
            end else begin
                e = q8.pop_front();
                chk({e.nm, "_out"}, out8, e.out);
                chk({e.nm, "_zero"}, zero8, (e.out == 32'h0));
                chk({e.nm, "_hi"}, hi8, e.hi);
                chk({e.nm, "_lo"}, lo8, e.lo);
                chk({e.nm, "_divzero"}, dz8, e.dz);
                chk({e.nm, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    // Issue one start; lat is the number of edges from the sampling edge to the edge that raises done.
    task automatic go(input bit w8, input string nm, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input int lat, input logic [31:0] eo,
                      input logic [31:0] eh, input logic [31:0] el, input logic edz);
        exp_t e;
        e.nm = nm; e.out = eo; e.hi = eh; e.lo = el; e.dz = edz;
        e.cyc = cyc + 1 + lat;
        if (w8) begin
            ctrl8 = op; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
            q8.push_back(e);
        end else begin
            ctrl32 = op; a32 = a; b32 = b; start32 = 1'b1;
            q32.push_back(e);
        end
        step();
        start32 = 1'b0; start8 = 1'b0;
        a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678; ctrl32 = ADD_;
        a8 = 8'h5A; b8 = 8'hC3; ctrl8 = ADD_;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
            step();
            n++;
        end
        chk("drain_timeout", (q32.size() != 0 || q8.size() != 0), 1'b0);
        q32.delete();
        q8.delete();
    endtask

    task automatic wait_done32();
        int n = 0;
        while (!done32 && n < 100) begin
            step();
            n++;
        end
        chk("wait_done32_timeout", done32, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        start32 = 1'b0; a32 = '0; b32 = '0; ctrl32 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0; ctrl8 = '0;
        step(); step();
        chk("rst_out", out32, 0);
        chk("rst_zero", zero32, 1);
        chk("rst_hi", hi32, 0);
        chk("rst_lo", lo32, 0);
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_divzero", dz32, 0);
        rst = 1'b0;
        step();

        go(0, "add_wrap", ADD_, 32'hFFFF_FFFF, 32'h1, 0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("add_busy", busy32, 0);
        drain();
        go(0, "slt_neg", SLT_, 32'hFFFF_FFFF, 32'h1, 0, 32'h1, 32'h0, 32'h0, 1'b0);
        go(0, "nor_zero", NOR_, 32'h0, 32'h0, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
        go(0, "sub_wrap", SUB_, 32'h5, 32'h7, 0, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b0);
        go(0, "or_mix", OR_, 32'hF000_000F, 32'h0F00_00F0, 0, 32'hFF00_00FF, 32'h0, 32'h0, 1'b0);
        drain();

        go(0, "multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32,
           32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        for (int i = 0; i < 32; i++) begin
            chk("multu_busy", busy32, 1);
            step();
        end
        chk("multu_busy_end", busy32, 0);
        drain();
        go(0, "mfhi", MFHI, 32'h0, 32'h0, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        go(0, "mflo", MFLO, 32'h0, 32'h0, 0, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        drain();

        go(0, "divu_100_7", DIVU, 32'd100, 32'd7, 32, 32'd14, 32'd2, 32'd14, 1'b0);
        repeat (5) step();
        ctrl32 = ADD_; a32 = 32'h1; b32 = 32'h1; start32 = 1'b1;
        step();
        start32 = 1'b0;
        drain();
        go(0, "divu_by_zero", DIVU, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 1'b1);
        chk("divzero_busy", busy32, 0);
        drain();
        go(0, "and_clears_dz", AND_, 32'hF0F0_1234, 32'h0FF0_FFFF, 0,
           32'h00F0_1234, 32'd5, 32'hFFFF_FFFF, 1'b0);
        drain();

        go(0, "b2b_divu", DIVU, 32'd1000, 32'd10, 32, 32'd100, 32'd0, 32'd100, 1'b0);
        wait_done32();
        go(0, "b2b_multu", MULTU, 32'h0001_0001, 32'h0001_0001, 32,
           32'h0002_0001, 32'h0000_0001, 32'h0002_0001, 1'b0);
        drain();

        go(1, "w8_multu", MULTU, 32'h80, 32'hFF, 8, 32'h80, 32'h7F, 32'h80, 1'b0);
        drain();
        go(1, "w8_divu", DIVU, 32'hF9, 32'h02, 8, 32'h7C, 32'h01, 32'h7C, 1'b0);
        drain();
`ifdef ALU_SIGNED_MULDIV_EN
        go(1, "w8_div_m7_2", DIV, 32'hF9, 32'h02, 8, 32'hFD, 32'hFF, 32'hFD, 1'b0);
        drain();
        go(1, "w8_mult_m128_m1", MULT, 32'h80, 32'hFF, 8, 32'h80, 32'h00, 32'h80, 1'b0);
        drain();
        go(1, "w8_div_minneg", DIV, 32'h80, 32'hFF, 8, 32'h80, 32'h00, 32'h80, 1'b0);
        drain();
        go(1, "w8_div_7_m2", DIV, 32'h07, 32'hFE, 8, 32'hFD, 32'h01, 32'hFD, 1'b0);
        drain();
`else
        go(1, "w8_div_off", DIV, 32'hF9, 32'h02, 0, 32'h00, 32'h01, 32'h7C, 1'b0);
        chk("w8_div_off_busy", busy8, 0);
        drain();
        go(1, "w8_mult_off", MULT, 32'h80, 32'hFF, 0, 32'h00, 32'h01, 32'h7C, 1'b0);
        drain();
`endif

        ctrl32 = MULTU; a32 = 32'd3; b32 = 32'd5; start32 = 1'b1;
        step();
        start32 = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        chk("abort_busy", busy32, 0);
        chk("abort_done", done32, 0);
        chk("abort_out", out32, 0);
        chk("abort_hi", hi32, 0);
        chk("abort_lo", lo32, 0);
        rst = 1'b0;
        repeat (40) step();
        go(0, "post_abort_mflo", MFLO, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
